// File: rtl/div18x18_2c.sv
// Sequential 18-bit signed divider, radix-2 restoring, one quotient bit
// per enabled cycle, with start/busy/done handshake.
module div18x18_2c (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        start,
   input  logic [17:0] A,
   input  logic [17:0] B,
   output logic [17:0] Q,
   output logic [17:0] R,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX
   } state_t;

   state_t      r_state;
   state_t      w_state_nx;
   logic [18:0] r_rem;
   logic [18:0] w_rem;
   logic [17:0] r_dvd;
   logic [17:0] w_dvd;
   logic [17:0] r_babs;
   logic [17:0] w_babs;
   logic [4:0]  r_cnt;
   logic [4:0]  w_cnt;
   logic        r_sign_q;
   logic        w_sign_q;
   logic        r_sign_r;
   logic        w_sign_r;
   logic [17:0] r_q;
   logic [17:0] w_q;
   logic [17:0] r_r;
   logic [17:0] w_r;
   logic        r_busy;
   logic        w_busy;
   logic        r_done;
   logic        w_done;
   logic [19:0] w_trial;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_rem    <= '0;
         r_dvd    <= '0;
         r_babs   <= '0;
         r_cnt    <= '0;
         r_sign_q <= 1'b0;
         r_sign_r <= 1'b0;
         r_q      <= '0;
         r_r      <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else if (en) begin
         r_state  <= w_state_nx;
         r_rem    <= w_rem;
         r_dvd    <= w_dvd;
         r_babs   <= w_babs;
         r_cnt    <= w_cnt;
         r_sign_q <= w_sign_q;
         r_sign_r <= w_sign_r;
         r_q      <= w_q;
         r_r      <= w_r;
         r_busy   <= w_busy;
         r_done   <= w_done;
      end
   end

   // Partial remainder stays below |B| <= 2^17, so its top bit is always 0.
   assign w_trial = {r_rem, r_dvd[17]} - {2'b00, r_babs};

   always_comb begin
      w_state_nx = r_state;
      w_rem      = r_rem;
      w_dvd      = r_dvd;
      w_babs     = r_babs;
      w_cnt      = r_cnt;
      w_sign_q   = r_sign_q;
      w_sign_r   = r_sign_r;
      w_q        = r_q;
      w_r        = r_r;
      w_busy     = r_busy;
      w_done     = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nx = S_CALC;
               w_sign_q   = (A[17] ^ B[17]) & (|B);
               w_sign_r   = A[17];
               w_dvd      = A[17] ? (18'd0 - A) : A;
               w_babs     = B[17] ? (18'd0 - B) : B;
               w_rem      = '0;
               w_cnt      = '0;
               w_busy     = 1'b1;
            end
         end
         S_CALC: begin
            if (!w_trial[19]) begin
               w_rem = w_trial[18:0];
               w_dvd = {r_dvd[16:0], 1'b1};
            end else begin
               w_rem = {r_rem[17:0], r_dvd[17]};
               w_dvd = {r_dvd[16:0], 1'b0};
            end
            w_cnt = r_cnt + 5'd1;
            if (r_cnt == 5'd17) begin
               w_state_nx = S_FIX;
            end
         end
         S_FIX: begin
            w_q        = r_sign_q ? (18'd0 - r_dvd) : r_dvd;
            w_r        = r_sign_r ? (18'd0 - r_rem[17:0]) : r_rem[17:0];
            w_done     = 1'b1;
            w_busy     = 1'b0;
            w_cnt      = '0;
            w_state_nx = S_IDLE;
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   assign Q    = r_q;
   assign R    = r_r;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_div18x18_2c.sv
// Self-checking bench for div18x18_2c: directed corner cases, enable
// stalls, reset abort and back-to-back randomised operands.
module tb_div18x18_2c;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        start;
   logic [17:0] A;
   logic [17:0] B;
   logic [17:0] Q;
   logic [17:0] R;
   logic        busy;
   logic        done;

   int ntests = 0;
   int nfail  = 0;

   div18x18_2c dut (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .start (start),
      .A     (A),
      .B     (B),
      .Q     (Q),
      .R     (R),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [17:0] obs,
                      input logic [17:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Truncating signed division on plain integers.
   function automatic void ref_div(input logic [17:0] a, input logic [17:0] b,
                                   output logic [17:0] q,
                                   output logic [17:0] r);
      int ia;
      int ib;
      ia = int'($signed(a));
      ib = int'($signed(b));
      if (ib == 0) begin
         q = 18'h3FFFF;
         r = a;
      end else begin
         q = 18'(ia / ib);
         r = 18'(ia % ib);
      end
   endfunction

   function automatic logic [17:0] rnd18();
      logic [17:0] v;
      case ($urandom_range(0, 9))
         0: v = 18'h00000;
         1: v = 18'h00001;
         2: v = 18'h3FFFF;
         3: v = 18'h20000;
         4: v = 18'h1FFFF;
         5: v = 18'($urandom_range(0, 15));
         default: v = 18'($urandom);
      endcase
      return v;
   endfunction

   // Drives start at a negedge and returns at the negedge where done is seen.
   task automatic run_op(input logic [17:0] a, input logic [17:0] b,
                         input string tag, input int stall_at,
                         input int inj_at, input int exp_lat);
      int          lat;
      int          bcnt;
      logic [17:0] eq;
      logic [17:0] er;
      lat   = 0;
      bcnt  = 0;
      start = 1'b1;
      A     = a;
      B     = b;
      while (lat < 200) begin
         @(negedge clk);
         lat++;
         en    = 1'b1;
         start = 1'b0;
         if (done) break;
         if (busy) bcnt++;
         if (stall_at > 0 && lat >= stall_at && lat < stall_at + 5) en = 1'b0;
         if (inj_at > 0 && lat == inj_at) begin
            start = 1'b1;
            A     = 18'd9;
            B     = 18'd2;
         end
      end
      ref_div(a, b, eq, er);
      chk({tag, " latency"}, 18'(lat), 18'(exp_lat));
      chk({tag, " busy cycles"}, 18'(bcnt), 18'(exp_lat - 1));
      chk({tag, " busy at done"}, 18'(busy), 18'd0);
      chk({tag, " Q"}, Q, eq);
      chk({tag, " R"}, R, er);
   endtask

   initial begin
      int          lat;
      int          ndone;
      logic [17:0] a;
      logic [17:0] b;
      logic [17:0] eq;
      logic [17:0] er;

      rst   = 1'b1;
      en    = 1'b1;
      start = 1'b0;
      A     = '0;
      B     = '0;
      repeat (2) @(negedge clk);
      chk("reset Q", Q, 18'd0);
      chk("reset R", R, 18'd0);
      chk("reset busy", 18'(busy), 18'd0);
      chk("reset done", 18'(done), 18'd0);
      rst = 1'b0;
      @(negedge clk);

      run_op(18'd100, 18'd7, "100/7", 0, 0, 20);
      chk("100/7 Q lit", Q, 18'h0000E);
      chk("100/7 R lit", R, 18'h00002);
      @(negedge clk);
      chk("done pulse clears", 18'(done), 18'd0);
      chk("Q held after done", Q, 18'h0000E);

      run_op(18'h3FF9C, 18'd7, "-100/7", 0, 0, 20);
      chk("-100/7 Q lit", Q, 18'h3FFF2);
      chk("-100/7 R lit", R, 18'h3FFFE);
      run_op(18'd100, 18'h3FFF9, "100/-7", 0, 0, 20);
      run_op(18'h3FF9C, 18'h3FFF9, "-100/-7", 0, 0, 20);
      run_op(18'd100, 18'd0, "div0", 0, 0, 20);
      chk("div0 Q lit", Q, 18'h3FFFF);
      run_op(18'h20000, 18'h3FFFF, "ovf", 0, 0, 20);
      chk("ovf Q lit", Q, 18'h20000);
      run_op(18'h1FFFF, 18'd1, "max/1", 0, 0, 20);

      // done must hold through disabled cycles
      en = 1'b0;
      repeat (3) @(negedge clk);
      chk("done held en=0", 18'(done), 18'd1);
      en = 1'b1;
      @(negedge clk);
      chk("done cleared en=1", 18'(done), 18'd0);

      run_op(18'd1000, 18'd3, "stall", $urandom_range(2, 12), 0, 25);
      chk("stall Q lit", Q, 18'd333);

      run_op(18'd12345, 18'd67, "inject", 0, 6, 20);
      ndone = 0;
      repeat (25) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("inject extra done", 18'(ndone), 18'd0);
      ref_div(18'd12345, 18'd67, eq, er);
      chk("inject Q kept", Q, eq);

      // abort mid-calculation
      start = 1'b1;
      A     = 18'd1000;
      B     = 18'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort busy", 18'(busy), 18'd0);
      chk("abort done", 18'(done), 18'd0);
      chk("abort Q", Q, 18'd0);
      chk("abort R", R, 18'd0);
      ndone = 0;
      repeat (25) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("abort no done", 18'(ndone), 18'd0);

      rst   = 1'b1;
      start = 1'b1;
      A     = 18'd5;
      B     = 18'd1;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk("rst beats start", 18'(busy), 18'd0);

      run_op(18'd50, 18'd5, "50/5", 0, 0, 20);
      chk("50/5 Q lit", Q, 18'd10);

      // back-to-back random, start held high throughout
      a     = rnd18();
      b     = rnd18();
      start = 1'b1;
      A     = a;
      B     = b;
      for (int i = 0; i < 1500; i++) begin
         lat = 0;
         do begin
            @(negedge clk);
            lat++;
         end while (!done && lat < 200);
         ref_div(a, b, eq, er);
         chk("b2b latency", 18'(lat), 18'd20);
         chk("b2b Q", Q, eq);
         chk("b2b R", R, er);
         a = rnd18();
         b = rnd18();
         A = a;
         B = b;
      end
      start = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
